// File: rtl/accu_win.sv
// Windowed accumulator: sums WIN_LEN accepted samples, then publishes the sum and overflow flag.
// Define ACCU_WIN_SAT_EN to clamp overflowing sums at all-ones instead of wrapping.
module accu_win #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ACC_W   = 10,
    parameter int unsigned WIN_LEN = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic [DATA_W-1:0]              in,
    input  logic                           clear,
    output logic [ACC_W-1:0]               acc,
    output logic [$clog2(WIN_LEN+1)-1:0]   cnt,
    output logic                           out_valid,
    output logic [ACC_W-1:0]               out_sum,
    output logic                           out_ovf
);

    localparam int unsigned CNT_W = $clog2(WIN_LEN + 1);

    typedef enum logic [0:0] {StIdle, StAccum} state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic               out_ovf_q, out_ovf_d;

    logic [ACC_W-1:0]   acc_base;
    logic [ACC_W:0]     in_ext;
    logic [ACC_W:0]     sum_wide;
    logic [ACC_W-1:0]   sum_next;
    logic               ovf_next;
    logic               last;

    // One spare bit above the accumulator catches the carry out of each addition.
    assign in_ext   = {{(ACC_W + 1 - DATA_W){1'b0}}, in};
    assign sum_wide = {1'b0, acc_base} + in_ext;
    assign ovf_next = ovf_q | sum_wide[ACC_W];
    assign last     = (cnt_q == CNT_W'(WIN_LEN - 1));

`ifdef ACCU_WIN_SAT_EN
    assign sum_next = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
    assign sum_next = sum_wide[ACC_W-1:0];
`endif

    always_comb begin
        acc_base = '0;
        unique case (state_q)
            StIdle:  acc_base = '0;
            StAccum: acc_base = acc_q;
            default: acc_base = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;
        if (clear) begin
            state_d = StIdle;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else if (in_valid) begin
            if (last) begin
                out_valid_d = 1'b1;
                out_sum_d   = sum_next;
                out_ovf_d   = ovf_next;
                state_d     = StIdle;
                acc_d       = '0;
                cnt_d       = '0;
                ovf_d       = 1'b0;
            end else begin
                state_d = StAccum;
                acc_d   = sum_next;
                cnt_d   = cnt_q + CNT_W'(1);
                ovf_d   = ovf_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign acc       = acc_q;
    assign cnt       = cnt_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;

endmodule
